// File: rtl/plab5_mcore_resp_net_inject_queue_pkg.sv
// Shared defaults and helpers for the memory-response network inject queue.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package plab5_mcore_resp_net_inject_queue_pkg;

  // Default widths of the response-network message: control carries
  // dest/src/opaque plus the memory response header, data carries the payload.
  localparam int unsigned RESP_NET_CNBITS  = 23;
  localparam int unsigned RESP_NET_DNBITS  = 32;
  localparam int unsigned RESP_NET_ENTRIES = 4;

  // Increment a ring pointer, wrapping at the number of slots.
  function automatic int unsigned ring_inc(input int unsigned ptr,
                                           input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/plab5_mcore_resp_queue_ctrl.sv
// Pointer, occupancy and handshake control for the response inject queue.
// Latency: handshakes are combinational from registered count; state updates on the clock edge.
// Backpressure: in_rdy drops when full (no enqueue even with a same-cycle dequeue); both handshakes low in reset.
module plab5_mcore_resp_queue_ctrl
  import plab5_mcore_resp_net_inject_queue_pkg::*;
#(
  parameter int unsigned p_num_entries = RESP_NET_ENTRIES,
  localparam int unsigned AW = $clog2(p_num_entries),
  localparam int unsigned CW = AW + 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val_i,
  input  logic          out_rdy_i,
  output logic          in_rdy_o,
  output logic          out_val_o,
  output logic          enq_o,
  output logic          deq_o,
  output logic [AW-1:0] enq_ptr_o,
  output logic [AW-1:0] deq_ptr_o,
  output logic [CW-1:0] count_o
);

  logic [AW-1:0] enq_ptr_q, enq_ptr_d;
  logic [AW-1:0] deq_ptr_q, deq_ptr_d;
  logic [CW-1:0] count_q,   count_d;

  // Handshakes derive only from registered occupancy, so there is no in-to-out path.
  always_comb begin
    in_rdy_o  = (count_q < CW'(p_num_entries)) && !reset;
    out_val_o = (count_q != '0) && !reset;
    enq_o     = in_val_i && in_rdy_o;
    deq_o     = out_val_o && out_rdy_i;
  end

  // Next-state pointers and occupancy; simultaneous enq+deq leaves count unchanged.
  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (enq_o) enq_ptr_d = AW'(ring_inc(int'(enq_ptr_q), p_num_entries));
    if (deq_o) deq_ptr_d = AW'(ring_inc(int'(deq_ptr_q), p_num_entries));
    if (enq_o && !deq_o)      count_d = count_q + CW'(1);
    else if (!enq_o && deq_o) count_d = count_q - CW'(1);
  end

  // Register pointer and occupancy state; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  assign enq_ptr_o = enq_ptr_q;
  assign deq_ptr_o = deq_ptr_q;
  assign count_o   = count_q;

endmodule

// File: rtl/plab5_mcore_resp_net_inject_queue.sv
// Domain-tagged FIFO between the mem-to-net response adapter and the network injection port.
// Latency: 1 cycle minimum from in_val to out_val (no bypass).
// Backpressure: valid/ready on both sides; in_rdy low when full, out_* held stable while out_rdy is low.
module plab5_mcore_resp_net_inject_queue
  import plab5_mcore_resp_net_inject_queue_pkg::*;
#(
  parameter int unsigned p_cnbits      = RESP_NET_CNBITS,
  parameter int unsigned p_dnbits      = RESP_NET_DNBITS,
  parameter int unsigned p_num_entries = RESP_NET_ENTRIES,
  localparam int unsigned AW = $clog2(p_num_entries),
  localparam int unsigned CW = AW + 1
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic                in_domain,
  input  logic [p_cnbits-1:0] in_control,
  input  logic [p_dnbits-1:0] in_data,
  output logic                out_val,
  input  logic                out_rdy,
  output logic                out_domain,
  output logic [p_cnbits-1:0] out_control,
  output logic [p_dnbits-1:0] out_data,
  output logic [CW-1:0]       count
);

  logic          enq;
  logic          deq;
  logic [AW-1:0] enq_ptr;
  logic [AW-1:0] deq_ptr;

  // Per-entry storage; domain, control and data of a slot travel together.
  logic                dom_q  [p_num_entries];
  logic [p_cnbits-1:0] ctrl_q [p_num_entries];
  logic [p_dnbits-1:0] data_q [p_num_entries];

  plab5_mcore_resp_queue_ctrl #(
    .p_num_entries (p_num_entries)
  ) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_val_i  (in_val),
    .out_rdy_i (out_rdy),
    .in_rdy_o  (in_rdy),
    .out_val_o (out_val),
    .enq_o     (enq),
    .deq_o     (deq),
    .enq_ptr_o (enq_ptr),
    .deq_ptr_o (deq_ptr),
    .count_o   (count)
  );

  // Write the enqueue slot, and scrub the data of a dequeued slot so no
  // high-domain payload lingers. Enq and deq never target the same slot in one
  // cycle: that would need the queue to be both empty and non-empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(p_num_entries); i++) begin
        dom_q[i]  <= 1'b0;
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(p_num_entries); i++) begin
        if (enq && (enq_ptr == AW'(i))) begin
          dom_q[i]  <= in_domain;
          ctrl_q[i] <= in_control;
          data_q[i] <= in_data;
        end else if (deq && (deq_ptr == AW'(i))) begin
          data_q[i] <= '0;
        end
      end
    end
  end

  // Present the head entry only while valid; otherwise drive all-zero.
  always_comb begin
    out_domain  = 1'b0;
    out_control = '0;
    out_data    = '0;
    if (out_val) begin
      out_domain  = dom_q[deq_ptr];
      out_control = ctrl_q[deq_ptr];
      out_data    = data_q[deq_ptr];
    end
  end

endmodule
